// File: rtl/selector41_pkg.sv
// Shared types for the 4-to-1 TDM selector: channel code and output-register FSM states.
package selector41_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] ch_code_t;
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;
endpackage

// File: rtl/selector41_tdm_if.sv
// Channel-side and stream-side signals of the 4-to-1 TDM selector.
interface selector41_tdm_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] iC0, iC1, iC2, iC3;
    logic             iV0, iV1, iV2, iV3;
    logic             oR0, oR1, oR2, oR3;
    logic [WIDTH-1:0] oC;
    logic             oS1, oS0, oV;
    logic             iR;

    modport slave  (input  iC0, iC1, iC2, iC3, iV0, iV1, iV2, iV3, iR,
                    output oR0, oR1, oR2, oR3, oC, oS1, oS0, oV);
    modport master (output iC0, iC1, iC2, iC3, iV0, iV1, iV2, iV3, iR,
                    input  oR0, oR1, oR2, oR3, oC, oS1, oS0, oV);
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; search starts just after the last winner.
module rr_arbiter4
    import selector41_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  ch_code_t          last_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_o,
    output ch_code_t          gnt_code_o
);
    ch_code_t idx;

    // i=NUM_CH wraps back to last itself, so it has the lowest priority
    always_comb begin
        gnt_o      = '0;
        gnt_code_o = '0;
        idx        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last_i + ch_code_t'(i);
            if (en_i && req_i[idx] && (gnt_o == '0)) begin
                gnt_o[idx] = 1'b1;
                gnt_code_o = idx;
            end
        end
    end
endmodule

// File: rtl/selector41_tdm.sv
// 4-to-1 time-division selector: round-robin collects channel words into one
// registered output stream tagged with the 2-bit source channel code.
module selector41_tdm
    import selector41_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic           iClk,
    input  logic           iRst_n,
    selector41_tdm_if.slave bus
);
    state_t           state_q, state_d;
    ch_code_t         last_q, code_q;
    logic [WIDTH-1:0] oC_q, data_sel;
    logic [3:0]       req, gnt;
    ch_code_t         gnt_code;
    logic             load_ok, arb_en, any_gnt;

    assign req     = {bus.iV3, bus.iV2, bus.iV1, bus.iV0};
    assign arb_en  = load_ok & iRst_n;
    assign any_gnt = |gnt;

    rr_arbiter4 u_arb (
        .req_i      (req),
        .last_i     (last_q),
        .en_i       (arb_en),
        .gnt_o      (gnt),
        .gnt_code_o (gnt_code)
    );

    always_ff @(posedge iClk) begin
        if (!iRst_n) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_gnt)            state_d = ST_FULL;
            ST_FULL:  if (bus.iR && !any_gnt) state_d = ST_EMPTY;
            default:                          state_d = ST_EMPTY;
        endcase
    end

    // A full register may only be overwritten in the cycle its word is consumed
    always_comb begin
        load_ok = (state_q == ST_EMPTY) | bus.iR;
    end

    always_comb begin
        case (gnt_code)
            2'd0:    data_sel = bus.iC0;
            2'd1:    data_sel = bus.iC1;
            2'd2:    data_sel = bus.iC2;
            default: data_sel = bus.iC3;
        endcase
    end

    // Pointer resets to 3 so channel 0 wins first
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oC_q   <= '0;
            code_q <= '0;
            last_q <= 2'd3;
        end else if (any_gnt) begin
            oC_q   <= data_sel;
            code_q <= gnt_code;
            last_q <= gnt_code;
        end
    end

    assign {bus.oR3, bus.oR2, bus.oR1, bus.oR0} = gnt;
    assign bus.oC             = oC_q;
    assign {bus.oS1, bus.oS0} = code_q;
    assign bus.oV             = (state_q == ST_FULL);
endmodule

// File: tb/tb_selector41_tdm.sv
// Directed + random bench for selector41_tdm with a reference model and word scoreboard.
module tb_selector41_tdm;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] iv, ic;
    logic       ir;

    int ncmp  = 0;
    int nfail = 0;

    // reference model state
    logic       m_full;
    logic [1:0] m_last, m_code;
    logic       m_oc;
    logic [2:0] q[$];

    logic [1:0] rc[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       rd[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    selector41_tdm_if #(.WIDTH(1)) bus ();

    assign bus.iV0 = iv[0];
    assign bus.iV1 = iv[1];
    assign bus.iV2 = iv[2];
    assign bus.iV3 = iv[3];
    assign bus.iC0 = ic[0];
    assign bus.iC1 = ic[1];
    assign bus.iC2 = ic[2];
    assign bus.iC3 = ic[3];
    assign bus.iR  = ir;

    selector41_tdm #(.WIDTH(1)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check accepts at negedge, push expected word, advance model, check outputs.
    task automatic cyc();
        logic [3:0] eg;
        logic [1:0] k, idx;
        logic       gok, lok;
        logic [2:0] w;
        @(negedge clk);
        lok = !m_full || ir;
        eg  = 4'b0;
        gok = 1'b0;
        k   = 2'd0;
        if (rst_n && lok) begin
            for (int i = 1; i <= 4; i++) begin
                idx = m_last + 2'(i);
                if (!gok && iv[idx]) begin
                    gok     = 1'b1;
                    k       = idx;
                    eg[idx] = 1'b1;
                end
            end
        end
        chk("oR", {bus.oR3, bus.oR2, bus.oR1, bus.oR0}, eg);
        if (gok) q.push_back({k, ic[k]});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_full = 1'b0; m_last = 2'd3; m_code = 2'd0; m_oc = 1'b0;
            q.delete();
        end else if (gok) begin
            m_full = 1'b1; m_last = k; m_code = k; m_oc = ic[k];
        end else if (lok) begin
            m_full = 1'b0;
        end
        chk("oV", bus.oV, m_full);
        chk("oC", bus.oC, m_oc);
        chk("oS", {bus.oS1, bus.oS0}, m_code);
        if (gok && q.size() > 0) begin
            w = q.pop_front();
            chk("sb_word", {bus.oS1, bus.oS0, bus.oC}, w);
        end
    endtask

    initial begin
        m_full = 1'b0; m_last = 2'd3; m_code = 2'd0; m_oc = 1'b0;
        // reset with every channel requesting
        rst_n = 1'b0; iv = 4'b1111; ic = 4'b1010; ir = 1'b1;
        cyc(); cyc();
        chk("rst_oV", bus.oV, 1'b0);

        // rotation 0,1,2,3,0 with data 0,1,0,1,0
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("rot_code", {bus.oS1, bus.oS0}, rc[n]);
            chk("rot_data", bus.oC, rd[n]);
        end

        // stall on code 10, then resume to channel 3
        iv = 4'b0100;
        cyc();
        chk("stall_load", {bus.oV, bus.oS1, bus.oS0}, 3'b110);
        ir = 1'b0; iv = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("stall_hold", {bus.oV, bus.oS1, bus.oS0}, 3'b110);
        end
        ir = 1'b1;
        cyc();
        chk("stall_resume", {bus.oV, bus.oS1, bus.oS0}, 3'b111);

        // single source served every cycle
        iv = 4'b0100;
        for (int n = 0; n < 6; n++) begin
            cyc();
            chk("single", {bus.oV, bus.oS1, bus.oS0}, 3'b110);
        end

        // mid-transfer reset
        iv = 4'b1111;
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midrst_oV", bus.oV, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("midrst_first", {bus.oV, bus.oS1, bus.oS0}, 3'b100);

        // random traffic and backpressure
        for (int n = 0; n < 60; n++) begin
            iv = 4'($urandom_range(0, 15));
            ic = 4'($urandom_range(0, 15));
            ir = 1'($urandom_range(0, 1));
            cyc();
        end

        // drain
        iv = 4'b0000; ir = 1'b1;
        cyc(); cyc();
        chk("drain_oV", bus.oV, 1'b0);
        chk("q_empty", 8'(q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
